// File: rtl/alu_core.sv
// alu_core: multi-cycle ALU with shift-add multiply and restoring divide (divider built only with ALU_DIV_EN)
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             div_zero,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE
`ifdef ALU_DIV_EN
    , S_DIV
`endif
  } state_t;
  state_t r_state, w_state;
  logic [WIDTH-1:0] r_hi, r_lo, r_b, w_hi, w_lo, w_b, w_res, w_res_hi;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [WIDTH:0] w_sum, w_diff, w_madd;
  logic w_load, w_carry, w_ill, w_last;
`ifdef ALU_DIV_EN
  logic [WIDTH:0] w_shift, w_dsub;
  logic w_dz;
`endif
  always_comb begin
    w_sum = {1'b0, a} + {1'b0, b};
    w_diff = {1'b0, a} - {1'b0, b};
    w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_last = r_cnt == CW'(WIDTH - 1);
`ifdef ALU_DIV_EN
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_dsub = w_shift - {1'b0, r_b};
    w_dz = 1'b0;
`endif
    w_state = r_state;
    w_hi = r_hi;
    w_lo = r_lo;
    w_b = r_b;
    w_cnt = r_cnt;
    w_load = 1'b0;
    w_res = '0;
    w_res_hi = '0;
    w_carry = 1'b0;
    w_ill = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state = S_DONE;
        w_load = 1'b1;
        w_hi = '0;
        w_lo = a;
        w_b = b;
        w_cnt = '0;
        case (operation)
          4'b0000: w_res = '0;
          4'b0001: {w_carry, w_res} = w_sum;
          4'b0010, 4'b1001: {w_carry, w_res} = w_diff;
          4'b0011: begin w_state = S_MUL; w_load = 1'b0; end
`ifdef ALU_DIV_EN
          4'b0100: if (b == '0) begin
            w_res = '1;
            w_res_hi = a;
            w_dz = 1'b1;
          end else begin
            w_state = S_DIV;
            w_load = 1'b0;
          end
`endif
          4'b0101: w_res = b;
          4'b0110: begin w_res = b; w_res_hi = a; end
          4'b0111: begin w_res = a & b; w_res_hi = a | b; end
          default: w_ill = 1'b1;
        endcase
      end
      S_MUL: begin
        {w_hi, w_lo} = {w_madd, r_lo[WIDTH-1:1]};
        w_cnt = r_cnt + 1'b1;
        if (w_last) begin
          w_state = S_DONE;
          w_load = 1'b1;
          w_res = w_lo;
          w_res_hi = w_hi;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        w_hi = w_dsub[WIDTH] ? w_shift[WIDTH-1:0] : w_dsub[WIDTH-1:0];
        w_lo = {r_lo[WIDTH-2:0], ~w_dsub[WIDTH]};
        w_cnt = r_cnt + 1'b1;
        if (w_last) begin
          w_state = S_DONE;
          w_load = 1'b1;
          w_res = w_lo;
          w_res_hi = w_hi;
        end
      end
`endif
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hi <= '0;
      r_lo <= '0;
      r_b <= '0;
      r_cnt <= '0;
      result <= '0;
      result_hi <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
      illegal <= 1'b0;
    end else begin
      r_state <= w_state;
      r_hi <= w_hi;
      r_lo <= w_lo;
      r_b <= w_b;
      r_cnt <= w_cnt;
      if (w_load) begin
        result <= w_res;
        result_hi <= w_res_hi;
        zero <= w_res == '0;
        carry <= w_carry;
        illegal <= w_ill;
      end
    end
  end
`ifdef ALU_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_zero <= 1'b0;
    else if (w_load) div_zero <= w_dz;
  end
  assign busy = (r_state == S_MUL) || (r_state == S_DIV);
`else
  assign div_zero = 1'b0;
  assign busy = r_state == S_MUL;
`endif
  assign done = r_state == S_DONE;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core with directed vectors
module tb_alu_core;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] operation = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, zero, carry, div_zero, illegal;
  logic [W-1:0] result, result_hi;
  alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .operation(operation), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .carry(carry), .div_zero(div_zero), .illegal(illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] r, h;
    logic z, c, dz, il;
    int due, id;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, n_vec = 0, n_err = 0, busy_total = 0, b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy) busy_total <= busy_total + 1;
    if (done) begin
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done at cycle %0d result=%h", cyc, result);
      end else begin
        e = q.pop_front();
        if ({result, result_hi, zero, carry, div_zero, illegal} !== {e.r, e.h, e.z, e.c, e.dz, e.il} || cyc != e.due) begin
          n_err++;
          $display("FAIL vec%0d got r=%h h=%h z=%b c=%b dz=%b il=%b cyc=%0d want r=%h h=%h z=%b c=%b dz=%b il=%b cyc=%0d",
                   e.id, result, result_hi, zero, carry, div_zero, illegal, cyc, e.r, e.h, e.z, e.c, e.dz, e.il, e.due);
        end
      end
    end
  end
  task automatic push(input logic [W-1:0] er, eh, input logic ez, ec, edz, eil, input int lat);
    n_vec++;
    q.push_back('{er, eh, ez, ec, edz, eil, cyc + lat, n_vec});
  endtask
  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL timeout pending=%0d", q.size());
      q.delete();
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [W-1:0] ia, ib, er, eh,
                       input logic ez, ec, edz, eil, input int lat, input int inj);
    @(negedge clk);
    operation = op; a = ia; b = ib; start = 1'b1;
    push(er, eh, ez, ec, edz, eil, lat);
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ~ib; operation = 4'b0001;
    if (inj > 0) begin
      repeat (inj - 1) @(negedge clk);
      start = 1'b1; a = 16'h0001; b = 16'h0001;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask
  task automatic chk(input string nm, input logic [63:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, done, result, result_hi, zero, carry, div_zero, illegal}, 0);
    rst = 1'b0;
    b0 = busy_total;
    issue(4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 1, 0, 0, 1, 0);
    chk("add_busy", busy_total - b0, 0);
    issue(4'b0001, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 0, 0, 0, 0, 1, 0);
    issue(4'b0010, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 0, 0, 0, 0, 1, 0);
    issue(4'b0010, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 0, 1, 0, 0, 1, 0);
    issue(4'b1001, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 0, 1, 0, 0, 1, 0);
    issue(4'b0110, 16'h0A0A, 16'h5050, 16'h5050, 16'h0A0A, 0, 0, 0, 0, 1, 0);
    issue(4'b0111, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'hFFF0, 0, 0, 0, 0, 1, 0);
    issue(4'b0111, 16'h00FF, 16'hFF00, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 1, 0);
    issue(4'b0101, 16'h1234, 16'hABCD, 16'hABCD, 16'h0000, 0, 0, 0, 0, 1, 0);
    issue(4'b0000, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 0);
    issue(4'b1111, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 0);
    issue(4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 0);
    b0 = busy_total;
    issue(4'b0011, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 0, 0, 0, 0, 17, 4);
    chk("mul_busy", busy_total - b0, 16);
    issue(4'b0011, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 0, 17, 0);
    issue(4'b0011, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, 0, 17, 0);
    repeat (3) @(negedge clk);
    chk("hold", {result, result_hi, zero, illegal}, {16'h0001, 16'hFFFE, 2'b00});
`ifdef ALU_DIV_EN
    issue(4'b0100, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 0, 0, 17, 0);
    issue(4'b0100, 16'h00AA, 16'h0000, 16'hFFFF, 16'h00AA, 0, 0, 1, 0, 1, 0);
    issue(4'b0100, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 17, 0);
`else
    issue(4'b0100, 16'd100, 16'd7, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 0);
    issue(4'b0100, 16'h00AA, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 0);
`endif
    issue(4'b0011, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, 0, 17, 0);
    @(negedge clk);
    operation = 4'b0011; a = 16'h1234; b = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_abort", {busy, done, result, result_hi, zero, carry, div_zero, illegal}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(4'b0001, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    operation = 4'b0001; a = 16'h0001; b = 16'h0001; start = 1'b1;
    push(16'h0002, 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    a = 16'h0002; b = 16'h0002;
    @(negedge clk);
    a = 16'h0003; b = 16'h0003;
    push(16'h0006, 16'h0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
